regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between the pipeline's writeback stage (WB) and a multi-cycle unit (MCU: mult/div or slow load) that completes out of pipeline order. WB writes are passed straight through with priority. MCU results are buffered in a small FIFO and drained on free write-port cycles. A starvation guard requests a one-cycle pipeline stall when the FIFO drain is blocked too long. Sits between WB/MCU and the register file write inputs (regWrite, writeRegister, writeData).

---
 rtl/regfile_write_arbiter.sv | 83 ++++++++
 tb/tb_regfile_write_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between WB (priority) and a buffered multi-cycle unit
module regfile_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbWrite,
  input  logic [4:0]  wbReg,
  input  logic [31:0] wbData,
  input  logic        mValid,
  input  logic [4:0]  mReg,
  input  logic [31:0] mData,
  output logic        mReady,
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData,
  output logic        stallReq,
  output logic [31:0] pendingMask
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]    mem_reg [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt, off;
  logic [CW-1:0] count, count_nxt;
  logic [SW-1:0] starve;
  logic [31:0]   mask_nxt;
  logic          wb_grant, pop, push, blocked;
  assign mReady    = !reset && count != CW'(DEPTH);
  assign wb_grant  = !stallReq && wbWrite && wbReg != 5'd0;
  assign pop       = count != '0 && !wb_grant;
  assign push      = mValid && mReady && mReg != 5'd0;
  assign blocked   = count != '0 && !pop;
  assign rd_nxt    = rd_ptr + AW'(pop);
  assign count_nxt = count + CW'(push) - CW'(pop);
  // occupancy mask of the FIFO as it will stand after this cycle's push and pop
  always_comb begin
    mask_nxt = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_nxt;
      if (CW'(off) < count_nxt) mask_nxt[(push && wr_ptr == AW'(i)) ? mReg : mem_reg[i]] = 1'b1;
    end
  end
  // FIFO storage; contents need no reset since validity comes from the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr]  <= mReg;
      mem_data[wr_ptr] <= mData;
    end
  end
  // pointers, write port grant, starvation guard and pending mask
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      starve        <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      stallReq      <= 1'b0;
      pendingMask   <= '0;
    end else begin
      rd_ptr      <= rd_nxt;
      wr_ptr      <= wr_ptr + AW'(push);
      count       <= count_nxt;
      pendingMask <= mask_nxt;
      regWrite    <= wb_grant || pop;
      if (wb_grant) begin
        writeRegister <= wbReg;
        writeData     <= wbData;
      end else if (pop) begin
        writeRegister <= mem_reg[rd_ptr];
        writeData     <= mem_data[rd_ptr];
      end
      starve   <= (!blocked || starve == SW'(STARVE_LIMIT - 1)) ? '0 : starve + SW'(1);
      stallReq <= blocked && starve == SW'(STARVE_LIMIT - 1);
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench for the register file write arbiter
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;
  localparam int STARVE = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic wbWrite = 1'b0, mValid = 1'b0;
  logic [4:0] wbReg = '0, mReg = '0;
  logic [31:0] wbData = '0, mData = '0;
  logic mReady, regWrite, stallReq;
  logic [4:0] writeRegister;
  logic [31:0] writeData, pendingMask;
  int n_vec = 0, n_err = 0;
  logic [36:0] mq[$];
  logic [36:0] exp_q[$];
  logic m_stall = 1'b0, e_wr = 1'b0, m_acc = 1'b0;
  int m_cnt = 0;
  logic [4:0] e_reg = '0;
  logic [31:0] e_data = '0;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset(reset), .wbWrite(wbWrite), .wbReg(wbReg), .wbData(wbData),
    .mValid(mValid), .mReg(mReg), .mData(mData), .mReady(mReady),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .stallReq(stallReq), .pendingMask(pendingMask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic grant, pop, blocked;
    logic [36:0] e;
    logic [31:0] mask;
    grant = !m_stall && wbWrite && wbReg != 5'd0;
    pop = mq.size() > 0 && !grant;
    blocked = mq.size() > 0 && !pop;
    m_acc = !reset && mValid && mq.size() < DEPTH;
    if (reset) begin
      mq.delete();
      m_stall = 1'b0;
      m_cnt = 0;
      e_wr = 1'b0;
      e_reg = '0;
      e_data = '0;
    end else begin
      e_wr = grant || pop;
      if (grant) exp_q.push_back({wbReg, wbData});
      else if (pop) exp_q.push_back(mq[0]);
      if (grant) {e_reg, e_data} = {wbReg, wbData};
      else if (pop) {e_reg, e_data} = mq[0];
      if (pop) e = mq.pop_front();
      if (m_acc && mReg != 5'd0) mq.push_back({mReg, mData});
      if (blocked && m_cnt + 1 == STARVE) begin
        m_stall = 1'b1;
        m_cnt = 0;
      end else begin
        m_stall = 1'b0;
        m_cnt = blocked ? m_cnt + 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    mask = '0;
    foreach (mq[i]) mask[mq[i][36:32]] = 1'b1;
    chk("regWrite", 32'(regWrite), 32'(e_wr));
    chk("stallReq", 32'(stallReq), 32'(m_stall));
    chk("pendingMask", pendingMask, mask);
    chk("mReady", 32'(mReady), 32'(!reset && mq.size() < DEPTH));
    chk("writeRegister", 32'(writeRegister), 32'(e_reg));
    chk("writeData", writeData, e_data);
    if (regWrite) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(writeRegister), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("sb_reg", 32'(writeRegister), 32'(e[36:32]));
        chk("sb_data", writeData, e[31:0]);
      end
    end
  endtask

  task automatic set_wb(input logic w, input logic [4:0] r, input logic [31:0] d);
    wbWrite = w;
    wbReg = r;
    wbData = d;
  endtask

  task automatic set_m(input logic v, input logic [4:0] r, input logic [31:0] d);
    mValid = v;
    mReg = r;
    mData = d;
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    chk("rst_regWrite", 32'(regWrite), 0);
    chk("rst_writeRegister", 32'(writeRegister), 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_mReady", 32'(mReady), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_mReady", 32'(mReady), 1);
    set_wb(1'b1, 5'd8, 32'hDEADBEEF);
    tick();
    chk("wb_reg", 32'(writeRegister), 8);
    chk("wb_data", writeData, 32'hDEADBEEF);
    set_wb(1'b1, 5'd0, 32'h1111_1111);
    tick();
    chk("wb_r0_nowrite", 32'(regWrite), 0);
    set_wb(1'b0, 5'd0, 0);
    set_m(1'b1, 5'd9, 32'h12345678);
    tick();
    set_m(1'b0, 5'd0, 0);
    chk("mcu_pending", pendingMask, 32'h0000_0200);
    tick();
    chk("mcu_write_reg", 32'(writeRegister), 9);
    chk("mcu_write_data", writeData, 32'h12345678);
    chk("mcu_pending_clear", pendingMask, 0);
    set_wb(1'b1, 5'd1, 32'hA0);
    set_m(1'b1, 5'd3, 32'h33);
    tick();
    set_wb(1'b1, 5'd2, 32'hA1);
    set_m(1'b1, 5'd5, 32'h55);
    tick();
    chk("full_mReady", 32'(mReady), 0);
    chk("full_mask", pendingMask, 32'h0000_0028);
    set_m(1'b1, 5'd7, 32'h77);
    for (int i = 0; i < 20; i++) begin
      set_wb(1'b1, 5'(4 + i % 4), 32'hB00 + 32'(i));
      tick();
      if (m_acc) set_m(1'b0, 5'd0, 0);
    end
    chk("held_accepted", 32'(mValid), 0);
    set_wb(1'b0, 5'd0, 0);
    repeat (4) tick();
    set_wb(1'b1, 5'd2, 32'hC0);
    set_m(1'b1, 5'd11, 32'hBB);
    tick();
    set_m(1'b0, 5'd0, 0);
    for (int i = 1; i <= STARVE; i++) begin
      wbData = 32'hC0 + 32'(i);
      tick();
      chk("starve_stall", 32'(stallReq), 32'(i == STARVE));
    end
    tick();
    chk("stall_pop_reg", 32'(writeRegister), 11);
    chk("stall_pulse", 32'(stallReq), 0);
    tick();
    chk("after_stall_wb_reg", 32'(writeRegister), 2);
    chk("after_stall_wb_data", writeData, 32'hC0 + 32'(STARVE));
    set_m(1'b1, 5'd20, 32'h20);
    tick();
    set_m(1'b1, 5'd21, 32'h21);
    tick();
    set_m(1'b0, 5'd0, 0);
    chk("pre_reset_mask", pendingMask, 32'h0030_0000);
    set_wb(1'b0, 5'd0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("midrst_mask", pendingMask, 0);
    chk("midrst_regWrite", 32'(regWrite), 0);
    repeat (4) tick();
    for (int i = 0; i < 400; i++) begin
      set_wb($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)) & ($urandom_range(0, 7) == 0 ? 5'd0 : 5'h1F), $urandom);
      if (!mValid && $urandom_range(0, 2) == 0) set_m(1'b1, 5'($urandom_range(0, 31)), $urandom);
      tick();
      if (m_acc) set_m(1'b0, 5'd0, 0);
    end
    set_wb(1'b0, 5'd0, 0);
    set_m(1'b0, 5'd0, 0);
    repeat (6) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
